// File: rtl/bubble_host_sequencer.sv
// bubble_host_sequencer
//   Host-side sequencer for a magnetic bubble memory drive. It accepts one
//   read command at a time and rotates the bubble loop (BS low) until the
//   target page reaches the replicate point. It then pulses the replicator
//   for three rotation ticks and shifts the requested number of bits in from
//   the detector, packing them into bytes. Finally it holds BS inactive for a
//   short stop period before returning to idle.
//
//   Clocking: master_clock (48 MHz) is the only clock. A free-running /4
//   divider provides the 12 MHz rotation tick. master_reset is synchronous,
//   active-high.
//
//   Ports:
//     cmd_valid / cmd_ready       command handshake (accepted in IDLE only)
//     cmd_position[11:0]          page position at which to replicate
//     cmd_bits[11:0]              number of bits to read (0 = replicate only)
//     cmd_bootloop                drive bootloop_enable for this command
//     abort                       cancel the active command (goes to STOP)
//     bubble_data_in              serial detector data
//     bubble_shift_enable         BS, active low: loop rotates while low
//     replicator_enable           REPEN, active low: replicate pulse
//     bootloop_enable             BOOTEN, active high
//     data_byte / data_valid      assembled byte plus one-cycle strobe
//     busy / done                 command in flight / one-cycle completion
//     current_position[11:0]      bubble loop position, survives commands
//
//   Build option: define BUBBLE_HOST_LSB_FIRST_EN to place the first sampled
//   bit of each byte in data_byte[0]. The default places it in data_byte[7].
module bubble_host_sequencer #(
  parameter int POSITIONS      = 2053,
  parameter int ROTATION_TICKS = 120,
  parameter int STOP_TICKS     = 8
) (
  input  logic        master_clock,
  input  logic        master_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_position,
  input  logic [11:0] cmd_bits,
  input  logic        cmd_bootloop,
  input  logic        abort,
  input  logic        bubble_data_in,
  output logic        bubble_shift_enable,
  output logic        replicator_enable,
  output logic        bootloop_enable,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic [11:0] current_position
);

  localparam int ROT_W  = $clog2(ROTATION_TICKS);
  localparam int STOP_W = $clog2(STOP_TICKS + 1);
  localparam logic [ROT_W-1:0]  ROT_ZERO    = ROT_W'(0);
  localparam logic [ROT_W-1:0]  ROT_ONE     = ROT_W'(1);
  localparam logic [ROT_W-1:0]  ROT_REP_END = ROT_W'(3);
  localparam logic [ROT_W-1:0]  SAMPLE_TICK = ROT_W'(60);
  localparam logic [ROT_W-1:0]  ROT_LAST    = ROT_W'(ROTATION_TICKS - 1);
  localparam logic [STOP_W-1:0] STOP_ZERO   = STOP_W'(0);
  localparam logic [STOP_W-1:0] STOP_ONE    = STOP_W'(1);
  localparam logic [STOP_W-1:0] STOP_LAST   = STOP_W'(STOP_TICKS - 1);
  localparam logic [11:0]       POS_LAST    = 12'(POSITIONS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEEK      = 3'd1,
    ST_REPLICATE = 3'd2,
    ST_READ      = 3'd3,
    ST_STOP      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         div_q, div_d;
  logic [ROT_W-1:0]   rot_q, rot_d;
  logic [11:0]        pos_q, pos_d;
  logic [STOP_W-1:0]  stop_cnt_q, stop_cnt_d;
  logic [11:0]        tgt_q, tgt_d;
  logic [11:0]        bits_left_q, bits_left_d;
  logic               boot_q, boot_d;
  logic               armed_q, armed_d;
  logic [7:0]         asm_q, asm_d;
  logic [2:0]         idx_q, idx_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               bs_q, bs_d;
  logic               repen_q, repen_d;
  logic               booten_q, booten_d;
  logic [7:0]         data_byte_q, data_byte_d;
  logic               data_valid_q, data_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick_s;
  logic               active_s;
  logic               active_next_s;
  logic [7:0]         asm_next_s;

  // Bit slot within the byte for the idx-th sampled bit.
  function automatic logic [2:0] bit_slot(input logic [2:0] idx);
`ifdef BUBBLE_HOST_LSB_FIRST_EN
    return idx;
`else
    return 3'd7 - idx;
`endif
  endfunction

  assign tick_s   = (div_q == 2'd3);
  assign active_s = (state_q == ST_SEEK) || (state_q == ST_REPLICATE) || (state_q == ST_READ);

  // Next-state, rotation/position tracking, byte assembly and output decode.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q + 2'd1;
    rot_d         = rot_q;
    pos_d         = pos_q;
    stop_cnt_d    = STOP_ZERO;
    tgt_d         = tgt_q;
    bits_left_d   = bits_left_q;
    boot_d        = boot_q;
    armed_d       = armed_q;
    asm_d         = asm_q;
    idx_d         = idx_q;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    asm_next_s    = asm_q;
    active_next_s = 1'b0;

    // The loop only rotates while BS is low, i.e. in the active states.
    if (tick_s && active_s) begin
      if (rot_q == ROT_LAST) begin
        rot_d = ROT_ZERO;
        pos_d = (pos_q == POS_LAST) ? 12'd0 : pos_q + 12'd1;
      end else begin
        rot_d = rot_q + ROT_ONE;
      end
    end else begin
      rot_d = rot_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          tgt_d       = cmd_position;
          bits_left_d = cmd_bits;
          boot_d      = cmd_bootloop;
          rot_d       = ROT_ZERO;
          state_d     = ST_SEEK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (abort) begin
          state_d = ST_STOP;
        end else if (tick_s && (rot_q == ROT_ZERO) && (pos_q == tgt_q)) begin
          state_d = ST_REPLICATE;
          armed_d = 1'b0;
          asm_d   = 8'd0;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_SEEK;
        end
      end
      ST_REPLICATE: begin
        // Entered with the counter moving 0->1, so REPEN is low for ticks 1..3.
        if (abort) begin
          state_d = ST_STOP;
        end else if (tick_s && (rot_q == ROT_REP_END)) begin
          state_d = (bits_left_q == 12'd0) ? ST_STOP : ST_READ;
        end else begin
          state_d = ST_REPLICATE;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_STOP;
        end else begin
          // The replicated bubble reaches the detector one position after
          // the replicate point, so sampling starts after the next wrap.
          if (tick_s && (rot_q == ROT_LAST)) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
          if (tick_s && armed_q && (rot_q == SAMPLE_TICK)) begin
            asm_next_s[bit_slot(idx_q)] = bubble_data_in;
            bits_left_d = bits_left_q - 12'd1;
            if ((idx_q == 3'd7) || (bits_left_q == 12'd1)) begin
              data_byte_d  = asm_next_s;
              data_valid_d = 1'b1;
              asm_d        = 8'd0;
              idx_d        = 3'd0;
            end else begin
              asm_d = asm_next_s;
              idx_d = idx_q + 3'd1;
            end
            state_d = (bits_left_q == 12'd1) ? ST_STOP : ST_READ;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_ONE;
          end
        end else begin
          stop_cnt_d = stop_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    active_next_s = (state_d == ST_SEEK) || (state_d == ST_REPLICATE) || (state_d == ST_READ);
    cmd_ready_d   = (state_d == ST_IDLE);
    bs_d          = ~active_next_s;
    repen_d       = (state_d != ST_REPLICATE);
    booten_d      = active_next_s ? boot_d : 1'b0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      state_q      <= ST_IDLE;
      div_q        <= 2'd0;
      rot_q        <= ROT_ZERO;
      pos_q        <= 12'd0;
      stop_cnt_q   <= STOP_ZERO;
      tgt_q        <= 12'd0;
      bits_left_q  <= 12'd0;
      boot_q       <= 1'b0;
      armed_q      <= 1'b0;
      asm_q        <= 8'd0;
      idx_q        <= 3'd0;
      cmd_ready_q  <= 1'b0;
      bs_q         <= 1'b1;
      repen_q      <= 1'b1;
      booten_q     <= 1'b0;
      data_byte_q  <= 8'd0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      rot_q        <= rot_d;
      pos_q        <= pos_d;
      stop_cnt_q   <= stop_cnt_d;
      tgt_q        <= tgt_d;
      bits_left_q  <= bits_left_d;
      boot_q       <= boot_d;
      armed_q      <= armed_d;
      asm_q        <= asm_d;
      idx_q        <= idx_d;
      cmd_ready_q  <= cmd_ready_d;
      bs_q         <= bs_d;
      repen_q      <= repen_d;
      booten_q     <= booten_d;
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign bubble_shift_enable = bs_q;
  assign replicator_enable   = repen_q;
  assign bootloop_enable     = booten_q;
  assign data_byte           = data_byte_q;
  assign data_valid          = data_valid_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign current_position    = pos_q;

endmodule

// File: tb/tb_bubble_host_sequencer.sv
// Self-checking bench for bubble_host_sequencer. A reduced loop length keeps
// the position wrap reachable in a short run; expected bytes are queued when
// a command is issued and compared as data_valid strobes arrive.
module tb_bubble_host_sequencer;

  localparam int POS = 20;
  localparam int RT  = 72;
  localparam int ST  = 8;

  logic        clk;
  logic        master_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_position;
  logic [11:0] cmd_bits;
  logic        cmd_bootloop;
  logic        abort;
  logic        bubble_data_in;
  logic        bubble_shift_enable;
  logic        replicator_enable;
  logic        bootloop_enable;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic [11:0] current_position;

  bubble_host_sequencer #(
    .POSITIONS      (POS),
    .ROTATION_TICKS (RT),
    .STOP_TICKS     (ST)
  ) dut (
    .master_clock        (clk),
    .master_reset        (master_reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_position        (cmd_position),
    .cmd_bits            (cmd_bits),
    .cmd_bootloop        (cmd_bootloop),
    .abort               (abort),
    .bubble_data_in      (bubble_data_in),
    .bubble_shift_enable (bubble_shift_enable),
    .replicator_enable   (replicator_enable),
    .bootloop_enable     (bootloop_enable),
    .data_byte           (data_byte),
    .data_valid          (data_valid),
    .busy                (busy),
    .done                (done),
    .current_position    (current_position)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  // Stream presented on bubble_data_in, indexed by loop position.
  logic       stream [0:31];
  int         stream_base = 0;
  int         stream_len  = 0;

  // Monitor state.
  int   cyc = 0;
  int   repen_pos = -1;
  int   repen_cycles = 0;
  bit   seen_zero = 1'b0;
  int   bs_rise_cyc = 0;
  int   stop_len = 0;
  int   done_count = 0;
  logic bs_prev = 1'b1;
  bit   boot_watch = 1'b0;
  bit   boot_bad = 1'b0;
  bit   boot_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Detector model: drives the bit belonging to the position under the head.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int idx;
        idx = (int'(current_position) - stream_base + POS) % POS;
        bubble_data_in = (idx < stream_len) ? stream[idx] : 1'b0;
      end
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (replicator_enable === 1'b0) begin
        if (repen_pos < 0) repen_pos = int'(current_position);
        repen_cycles++;
      end
      if (current_position === 12'd0) seen_zero = 1'b1;
      if (bubble_shift_enable === 1'b1 && bs_prev === 1'b0) bs_rise_cyc = cyc;
      bs_prev = bubble_shift_enable;
      if (done === 1'b1) begin
        done_count++;
        stop_len = cyc - bs_rise_cyc;
      end
      if (boot_watch && bubble_shift_enable === 1'b0) begin
        if (bootloop_enable !== 1'b1) boot_bad = 1'b1;
        else boot_seen = 1'b1;
      end
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) check_eq("spurious_data_valid", {31'd0, data_valid}, 32'd0);
        else check_eq("data_byte", {24'd0, data_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input int pos, input int bits, input logic boot, input logic with_abort);
    int n;
    repen_pos    = -1;
    repen_cycles = 0;
    seen_zero    = 1'b0;
    @(negedge clk);
    cmd_position = 12'(pos);
    cmd_bits     = 12'(bits);
    cmd_bootloop = boot;
    abort        = with_abort;
    cmd_valid    = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_eq("done_timeout", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_stream(input int base, input int len, input logic [31:0] bits);
    stream_base = base % POS;
    stream_len  = len;
    for (int i = 0; i < 32; i++) stream[i] = bits[31-i];
  endtask

  initial begin
    int dc;
    int n;
    master_reset = 1'b1;
    cmd_valid = 1'b0; cmd_position = 12'd0; cmd_bits = 12'd0;
    cmd_bootloop = 1'b0; abort = 1'b0; bubble_data_in = 1'b0;
    for (int i = 0; i < 32; i++) stream[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bs", {31'd0, bubble_shift_enable}, 32'd1);
    check_eq("rst_repen", {31'd0, replicator_enable}, 32'd1);
    check_eq("rst_booten", {31'd0, bootloop_enable}, 32'd0);
    check_eq("rst_data_byte", {24'd0, data_byte}, 32'd0);
    check_eq("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_position", {20'd0, current_position}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    master_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Basic read: replicate at 5, bits 1,0,1,1,0,0,1,0 from position 6.
    set_stream(6, 8, 32'hB200_0000);
`ifdef BUBBLE_HOST_LSB_FIRST_EN
    exp_q.push_back(8'h4D);
`else
    exp_q.push_back(8'hB2);
`endif
    issue(5, 8, 1'b0, 1'b0);
    check_eq("seek_busy", {31'd0, busy}, 32'd1);
    check_eq("seek_bs", {31'd0, bubble_shift_enable}, 32'd0);
    check_eq("seek_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wait_done();
    check_eq("t1_repen_pos", 32'(repen_pos), 32'd5);
    check_eq("t1_repen_cycles", 32'(repen_cycles), 32'd12);
    check_eq("t1_position", {20'd0, current_position}, 32'd13);
    check_eq("t1_stop_len", 32'(stop_len), 32'(4 * ST));
    check_eq("t1_bytes_left", 32'(exp_q.size()), 32'd0);

    // 12 ones: a full byte then a zero-padded partial byte; wraps 19->0.
    set_stream(15, 12, 32'hFFF0_0000);
    exp_q.push_back(8'hFF);
`ifdef BUBBLE_HOST_LSB_FIRST_EN
    exp_q.push_back(8'h0F);
`else
    exp_q.push_back(8'hF0);
`endif
    issue(14, 12, 1'b0, 1'b0);
    wait_done();
    check_eq("t2_position", {20'd0, current_position}, 32'((14 + 12) % POS));
    check_eq("t2_bytes_left", 32'(exp_q.size()), 32'd0);

    // Abort after 3 bits of a 16-bit read: no bytes, stop period, done.
    set_stream(9, 16, $urandom);
    dc = done_count;
    issue(8, 16, 1'b0, 1'b0);
    n = 0;
    while (current_position !== 12'd12 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_eq("t3_pos_timeout", {20'd0, current_position}, 32'd12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t3_bs_after_abort", {31'd0, bubble_shift_enable}, 32'd1);
    check_eq("t3_repen_after_abort", {31'd0, replicator_enable}, 32'd1);
    wait_done();
    check_eq("t3_stop_len_ok", {31'd0, (stop_len >= 4 * ST - 3) && (stop_len <= 4 * ST)}, 32'd1);
    check_eq("t3_done_pulses", 32'(done_count - dc), 32'd1);
    check_eq("t3_position", {20'd0, current_position}, 32'd12);

    // Bootloop, zero bits, abort raised together with the command in IDLE.
    stream_len = 0;
    boot_bad = 1'b0; boot_seen = 1'b0; boot_watch = 1'b1;
    issue(13, 0, 1'b1, 1'b1);
    check_eq("t4_accepted_busy", {31'd0, busy}, 32'd1);
    wait_done();
    boot_watch = 1'b0;
    check_eq("t4_booten_dropout", {31'd0, boot_bad}, 32'd0);
    check_eq("t4_booten_seen", {31'd0, boot_seen}, 32'd1);
    check_eq("t4_booten_idle", {31'd0, bootloop_enable}, 32'd0);
    check_eq("t4_repen_cycles", 32'(repen_cycles), 32'd12);
    check_eq("t4_position", {20'd0, current_position}, 32'd13);

    // Park at the last position, then seek across the wrap to position 1.
    issue(POS - 1, 0, 1'b0, 1'b0);
    wait_done();
    check_eq("t5_park_position", {20'd0, current_position}, 32'(POS - 1));
    issue(1, 0, 1'b0, 1'b0);
    wait_done();
    check_eq("t5_seen_zero", {31'd0, seen_zero}, 32'd1);
    check_eq("t5_repen_pos", 32'(repen_pos), 32'd1);
    check_eq("t5_position", {20'd0, current_position}, 32'd1);

    // Reset in the middle of a seek.
    dc = done_count;
    issue(10, 4, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_eq("t6_booten_seek", {31'd0, bootloop_enable}, 32'd1);
    master_reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_bs", {31'd0, bubble_shift_enable}, 32'd1);
    check_eq("t6_repen", {31'd0, replicator_enable}, 32'd1);
    check_eq("t6_booten", {31'd0, bootloop_enable}, 32'd0);
    check_eq("t6_data_byte", {24'd0, data_byte}, 32'd0);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("t6_position", {20'd0, current_position}, 32'd0);
    @(negedge clk);
    master_reset = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("t6_no_done", 32'(done_count - dc), 32'd0);
    check_eq("t6_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("final_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
